mc_control: RTL and testbench

- Multi-cycle successor to the single-cycle main control decoder.
- Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles for R-type, lw, sw, beq, addi and lui.
- Drives the shared-ALU, shared-memory datapath: IorD/IRWrite muxes, PC write enables and register-file write.
- Stalls on a memory ready handshake.

---
 rtl/mc_control_pkg.sv | 54 +++++
 rtl/mc_control_if.sv | 39 +++
 rtl/mc_control_opdecode.sv | 29 ++
 rtl/mc_control.sv | 166 ++++++++++++++++
 tb/tb_mc_control.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mc_control_pkg.sv
// mc_control_pkg: shared constants for the multi-cycle main controller.
// State encodings, opcode values, ALU operation classes, mux select codes
// and the one-hot opcode class produced by mc_opdecode.
package mc_control_pkg;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_ADDIEX = 4'd9;
   localparam logic [3:0] S_ADDIWB = 4'd10;
   localparam logic [3:0] S_LUIEX  = 4'd11;
   localparam logic [3:0] S_JUMP   = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LUI   = 6'd15;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;
   localparam logic [1:0] ALU_LUI   = 2'd3;

   localparam logic [1:0] SRCB_RT     = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMMSH2 = 2'd3;

   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   typedef struct packed {
      logic rtype;
      logic mem;
      logic lw;
      logic sw;
      logic beq;
      logic addi;
      logic lui;
      logic jump;
      logic illegal;
   } op_class_t;

endpackage

// File: rtl/mc_control_if.sv
// mc_control_if: controller <-> datapath/memory signal bundle.
// master = controller side, slave = datapath/memory side.
interface mc_control_if #(
   parameter int OPW    = 6,
   parameter int ALUOPW = 2,
   parameter int STATEW = 4
);
   logic [OPW-1:0]    opcode;
   logic              mem_ready;
   logic              mem_req;
   logic              iord;
   logic              memread;
   logic              memwrite;
   logic              irwrite;
   logic              regdst;
   logic              memtoreg;
   logic              regwrite;
   logic              alusrca;
   logic [1:0]        alusrcb;
   logic [ALUOPW-1:0] aluop;
   logic [1:0]        pcsrc;
   logic              pcwrite;
   logic              pcwritecond;
   logic [STATEW-1:0] state_o;

   modport master (
      input  opcode, mem_ready,
      output mem_req, iord, memread, memwrite, irwrite, regdst, memtoreg,
             regwrite, alusrca, alusrcb, aluop, pcsrc, pcwrite, pcwritecond,
             state_o
   );

   modport slave (
      output opcode, mem_ready,
      input  mem_req, iord, memread, memwrite, irwrite, regdst, memtoreg,
             regwrite, alusrca, alusrcb, aluop, pcsrc, pcwrite, pcwritecond,
             state_o
   );
endinterface

// File: rtl/mc_control_opdecode.sv
// mc_opdecode: combinational opcode -> one-hot instruction class.
// MC_CONTROL_JUMP_EN: when undefined, opcode 2 decodes as illegal.
module mc_opdecode
   import mc_control_pkg::*;
#(
   parameter int OPW = 6
) (
   input  logic [OPW-1:0] opcode,
   output op_class_t      cls
);

   // Classify the opcode; anything unrecognised is illegal (NOP).
   always_comb begin
      cls = '0;
      case (opcode)
         OPW'(OP_RTYPE): cls.rtype = 1'b1;
         OPW'(OP_LW):    begin cls.mem = 1'b1; cls.lw = 1'b1; end
         OPW'(OP_SW):    begin cls.mem = 1'b1; cls.sw = 1'b1; end
         OPW'(OP_BEQ):   cls.beq   = 1'b1;
         OPW'(OP_ADDI):  cls.addi  = 1'b1;
         OPW'(OP_LUI):   cls.lui   = 1'b1;
`ifdef MC_CONTROL_JUMP_EN
         OPW'(OP_J):     cls.jump  = 1'b1;
`endif
         default:        cls.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle Moore main controller for the shared-ALU,
// shared-memory datapath. Stalls FETCH/MEMRD/MEMWR on mem_ready.
// MC_CONTROL_JUMP_EN: builds the JUMP state (opcode 2).
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 (commits on mem_ready)
// DECODE | read registers, precompute branch target
// MEMADR | compute rs + imm address
// MEMRD  | load read, held until mem_ready
// MEMWB  | write MDR to rt
// MEMWR  | store write, held until mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | write ALUOut to rd
// BRANCH | compare rs/rt, conditional PC write
// ADDIEX | rs + imm
// ADDIWB | write ALUOut to rt (shared by addi and lui)
// LUIEX  | imm << 16
// JUMP   | PC <- jump target (optional)
module mc_control
   import mc_control_pkg::*;
#(
   parameter int OPW    = 6,
   parameter int ALUOPW = 2,
   parameter int STATEW = 4
) (
   input  logic         clk,
   input  logic         reset,
   mc_control_if.master bus
);

   logic [3:0]  state;
   logic [3:0]  state_nxt;
   op_class_t   cls;

   mc_opdecode #(.OPW(OPW)) u_opdecode (
      .opcode (bus.opcode),
      .cls    (cls)
   );

   // Next-state selection; unknown encodings fall back to FETCH.
   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_FETCH:  state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (cls.rtype)        state_nxt = S_EXEC;
            else if (cls.mem)     state_nxt = S_MEMADR;
            else if (cls.beq)     state_nxt = S_BRANCH;
            else if (cls.addi)    state_nxt = S_ADDIEX;
            else if (cls.lui)     state_nxt = S_LUIEX;
`ifdef MC_CONTROL_JUMP_EN
            else if (cls.jump)    state_nxt = S_JUMP;
`else
            else if (cls.jump)    state_nxt = S_FETCH;
`endif
            else if (cls.illegal) state_nxt = S_FETCH;
         end
         S_MEMADR: begin
            if (cls.lw)           state_nxt = S_MEMRD;
            else if (cls.sw)      state_nxt = S_MEMWR;
         end
         S_MEMRD:  state_nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_nxt = S_FETCH;
         S_MEMWR:  state_nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_nxt = S_ALUWB;
         S_ALUWB:  state_nxt = S_FETCH;
         S_BRANCH: state_nxt = S_FETCH;
         S_ADDIEX: state_nxt = S_ADDIWB;
         S_ADDIWB: state_nxt = S_FETCH;
         S_LUIEX:  state_nxt = S_ADDIWB;
`ifdef MC_CONTROL_JUMP_EN
         S_JUMP:   state_nxt = S_FETCH;
`endif
         default:  state_nxt = S_FETCH;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nxt;
   end

   // Moore outputs; everything held at 0 while reset is high. The FETCH
   // commit strobes are qualified by mem_ready so a stalled fetch commits once.
   always_comb begin
      bus.mem_req     = 1'b0;
      bus.iord        = 1'b0;
      bus.memread     = 1'b0;
      bus.memwrite    = 1'b0;
      bus.irwrite     = 1'b0;
      bus.regdst      = 1'b0;
      bus.memtoreg    = 1'b0;
      bus.regwrite    = 1'b0;
      bus.alusrca     = 1'b0;
      bus.alusrcb     = SRCB_RT;
      bus.aluop       = ALUOPW'(ALU_ADD);
      bus.pcsrc       = PC_ALU;
      bus.pcwrite     = 1'b0;
      bus.pcwritecond = 1'b0;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               bus.mem_req = 1'b1;
               bus.memread = 1'b1;
               bus.alusrcb = SRCB_FOUR;
               bus.irwrite = bus.mem_ready;
               bus.pcwrite = bus.mem_ready;
            end
            S_DECODE: bus.alusrcb = SRCB_IMMSH2;
            S_MEMADR: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
               bus.mem_req = 1'b1;
               bus.memread = 1'b1;
               bus.iord    = 1'b1;
            end
            S_MEMWB: begin
               bus.regwrite = 1'b1;
               bus.memtoreg = 1'b1;
            end
            S_MEMWR: begin
               bus.mem_req  = 1'b1;
               bus.memwrite = 1'b1;
               bus.iord     = 1'b1;
            end
            S_EXEC: begin
               bus.alusrca = 1'b1;
               bus.aluop   = ALUOPW'(ALU_FUNCT);
            end
            S_ALUWB: begin
               bus.regwrite = 1'b1;
               bus.regdst   = 1'b1;
            end
            S_BRANCH: begin
               bus.alusrca     = 1'b1;
               bus.aluop       = ALUOPW'(ALU_SUB);
               bus.pcwritecond = 1'b1;
               bus.pcsrc       = PC_ALUOUT;
            end
            S_ADDIEX: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = SRCB_IMM;
            end
            S_ADDIWB: bus.regwrite = 1'b1;
            S_LUIEX: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = SRCB_IMM;
               bus.aluop   = ALUOPW'(ALU_LUI);
            end
`ifdef MC_CONTROL_JUMP_EN
            S_JUMP: begin
               bus.pcwrite = 1'b1;
               bus.pcsrc   = PC_JUMP;
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.state_o = STATEW'(state);

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized instruction streams checked against a
// phase-sequence reference model of the multi-cycle controller.
module tb_mc_control;
   import mc_control_pkg::*;

   typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                     P_EXEC, P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_LUIEX,
                     P_JUMP} ph_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   mc_control_if #(.OPW(6), .ALUOPW(2), .STATEW(4)) bus ();

   mc_control #(.OPW(6), .ALUOPW(2), .STATEW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [16:0] outs;
   assign outs = {bus.mem_req, bus.iord, bus.memread, bus.memwrite, bus.irwrite,
                  bus.regdst, bus.memtoreg, bus.regwrite, bus.alusrca,
                  bus.alusrcb, bus.aluop, bus.pcsrc, bus.pcwrite, bus.pcwritecond};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Expected output bundle for one phase of an instruction.
   function automatic logic [16:0] exp_outs(input ph_t ph, input logic rdy);
      logic req = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0, m2r = 0, rw = 0;
      logic srca = 0, pcw = 0, pcwc = 0;
      logic [1:0] srcb = 0, aop = 0, pcs = 0;
      case (ph)
         P_FETCH:  begin req = 1; mrd = 1; srcb = 1; irw = rdy; pcw = rdy; end
         P_DECODE: srcb = 3;
         P_MEMADR: begin srca = 1; srcb = 2; end
         P_MEMRD:  begin req = 1; mrd = 1; iord = 1; end
         P_MEMWB:  begin rw = 1; m2r = 1; end
         P_MEMWR:  begin req = 1; mwr = 1; iord = 1; end
         P_EXEC:   begin srca = 1; aop = 2; end
         P_ALUWB:  begin rw = 1; rdst = 1; end
         P_BRANCH: begin srca = 1; aop = 1; pcwc = 1; pcs = 1; end
         P_ADDIEX: begin srca = 1; srcb = 2; end
         P_ADDIWB: rw = 1;
         P_LUIEX:  begin srca = 1; srcb = 2; aop = 3; end
         P_JUMP:   begin pcw = 1; pcs = 2; end
         default: ;
      endcase
      return {req, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aop, pcs, pcw, pcwc};
   endfunction

   function automatic logic [3:0] exp_state(input ph_t ph);
      case (ph)
         P_FETCH:  return S_FETCH;
         P_DECODE: return S_DECODE;
         P_MEMADR: return S_MEMADR;
         P_MEMRD:  return S_MEMRD;
         P_MEMWB:  return S_MEMWB;
         P_MEMWR:  return S_MEMWR;
         P_EXEC:   return S_EXEC;
         P_ALUWB:  return S_ALUWB;
         P_BRANCH: return S_BRANCH;
         P_ADDIEX: return S_ADDIEX;
         P_ADDIWB: return S_ADDIWB;
         P_LUIEX:  return S_LUIEX;
         default:  return S_JUMP;
      endcase
   endfunction

   // Zero-wait cycle count per opcode (illegal = fetch + decode).
   function automatic int base_cycles(input logic [5:0] op);
      case (op)
         6'd0:  return 4;
         6'd35: return 5;
         6'd43: return 4;
         6'd4:  return 3;
         6'd8:  return 4;
         6'd15: return 4;
`ifdef MC_CONTROL_JUMP_EN
         6'd2:  return 3;
`endif
         default: return 2;
      endcase
   endfunction

   // Runs one instruction from FETCH back to FETCH. fst/mst are the
   // mem_ready=0 cycles injected in FETCH and in the memory-access phase.
   task automatic run_instr(input logic [5:0] op, input int fst, input int mst);
      ph_t q[$];
      int  idx = 0, stall = 0, cyc = 0, lim;
      bit  seen = 0, done = 0, waits;
      ph_t ph;
      q.push_back(P_FETCH);
      q.push_back(P_DECODE);
      case (op)
         6'd0:  begin q.push_back(P_EXEC); q.push_back(P_ALUWB); end
         6'd35: begin q.push_back(P_MEMADR); q.push_back(P_MEMRD); q.push_back(P_MEMWB); end
         6'd43: begin q.push_back(P_MEMADR); q.push_back(P_MEMWR); end
         6'd4:  q.push_back(P_BRANCH);
         6'd8:  begin q.push_back(P_ADDIEX); q.push_back(P_ADDIWB); end
         6'd15: begin q.push_back(P_LUIEX); q.push_back(P_ADDIWB); end
`ifdef MC_CONTROL_JUMP_EN
         6'd2:  q.push_back(P_JUMP);
`endif
         default: ;
      endcase
      bus.opcode = op;
      while (!done) begin
         ph = (idx < q.size()) ? q[idx] : P_FETCH;
         waits = (ph == P_FETCH) || (ph == P_MEMRD) || (ph == P_MEMWR);
         lim = (ph == P_FETCH) ? fst : mst;
         if (waits) bus.mem_ready = (stall < lim) ? 1'b0 : 1'b1;
         else       bus.mem_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk($sformatf("outs op=%0d ph=%0d", op, ph), 32'(outs), 32'(exp_outs(ph, bus.mem_ready)));
         chk($sformatf("state op=%0d ph=%0d", op, ph), 32'(bus.state_o), 32'(exp_state(ph)));
         if (bus.state_o != S_FETCH) seen = 1;
         if (waits && !bus.mem_ready) stall++;
         else begin idx++; stall = 0; end
         cyc++;
         @(posedge clk); #1;
         if (seen && bus.state_o == S_FETCH) done = 1;
         if (cyc >= 40) begin
            chk($sformatf("timeout op=%0d", op), 32'(cyc), 32'(0));
            done = 1;
         end
      end
      chk($sformatf("cycles op=%0d", op), 32'(cyc),
          32'(base_cycles(op) + fst + ((op == 6'd35 || op == 6'd43) ? mst : 0)));
   endtask

   logic [5:0] ops [7] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd15, 6'd2};

   initial begin
      logic [5:0] op;
      int sel, steps;
      bus.opcode    = 6'd0;
      bus.mem_ready = 1'b1;
      reset         = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("reset_outs", 32'(outs), 32'(0));
         @(posedge clk); #1;
      end
      chk("reset_state", 32'(bus.state_o), 32'(S_FETCH));
      reset = 1'b0;

      run_instr(6'd0, 0, 0);
      run_instr(6'd35, 0, 3);
      run_instr(6'd43, 2, 0);
      run_instr(6'd4, 0, 0);
      run_instr(6'd15, 0, 0);
      run_instr(6'd63, 0, 0);
      run_instr(6'd2, 0, 0);
      run_instr(6'd8, 1, 1);
      run_instr(6'd43, 0, 2);

      for (int n = 0; n < 200; n++) begin
         sel = $urandom_range(0, 7);
         op  = (sel < 7) ? ops[sel] : 6'($urandom_range(0, 63));
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // Reset taken in the middle of a stalled store.
      bus.opcode    = 6'd43;
      bus.mem_ready = 1'b1;
      steps = 0;
      while (bus.state_o != S_MEMWR && steps < 10) begin
         @(posedge clk); #1;
         if (bus.state_o != S_FETCH) bus.mem_ready = 1'b0;
         steps++;
      end
      chk("reach_memwr", 32'(bus.state_o), 32'(S_MEMWR));
      @(negedge clk);
      chk("memwr_stall_write", 32'(bus.memwrite), 32'(1));
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("memwr_reset_outs", 32'(outs), 32'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      chk("memwr_reset_state", 32'(bus.state_o), 32'(S_FETCH));
      run_instr(6'd0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
